// File: rtl/ibuf_write_sequencer_if.sv
// Stream-in and buffer-write bus of the input line buffer feeder.
// master: producer of the feature stream / consumer of the writes (bench or upstream glue).
// slave : the sequencer itself.
interface ibuf_write_sequencer_if #(
  parameter int DW = 32
);
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] wdata;
  logic [7:0]    wbank;
  logic [7:0]    wrow;
  logic [27:0]   wcol;
  logic          wen;

  modport master (
    output in_data, in_valid,
    input  in_ready,
    input  wdata, wbank, wrow, wcol, wen
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready,
    output wdata, wbank, wrow, wcol, wen
  );
endinterface

// File: rtl/ibuf_write_sequencer.sv
// ibuf_write_sequencer: turns a stream of feature rows (BUFW words each) into
// per-word input-buffer writes. Row y lands in bank y%POY, slot (y/POY)%BUFH.
// A pool of LINES credits, refilled by line_rel from the router, keeps the
// writer from overrunning lines that have not been consumed yet.
// Optional feature: define IBUF_SEQ_STATS_EN to add the stall_cnt output.
module ibuf_write_sequencer #(
  parameter int DW     = 32,
  parameter int POY    = 3,
  parameter int STRIDE = 1,
  parameter int BUFW   = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [15:0]                 num_rows,
  input  logic                        line_rel,
  ibuf_write_sequencer_if.slave       bus,
  output logic                        busy,
  output logic                        done,
  output logic                        credit_err
`ifdef IBUF_SEQ_STATS_EN
  ,
  output logic [31:0]                 stall_cnt
`endif
);

  localparam int BUFH  = 2 * STRIDE;
  localparam int LINES = POY * BUFH;
  localparam int CW    = $clog2(LINES + 1);
  localparam int COLW  = (BUFW > 1) ? $clog2(BUFW) : 1;
  localparam int BANKW = (POY > 1)  ? $clog2(POY)  : 1;
  localparam int SLOTW = (BUFH > 1) ? $clog2(BUFH) : 1;

  localparam logic [CW-1:0]    CRED_FULL = CW'(LINES);
  localparam logic [COLW-1:0]  COL_LAST  = COLW'(BUFW - 1);
  localparam logic [BANKW-1:0] BANK_LAST = BANKW'(POY - 1);
  localparam logic [SLOTW-1:0] SLOT_LAST = SLOTW'(BUFH - 1);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t           state_q;
  logic [COLW-1:0]  col_q;
  logic [BANKW-1:0] bank_q;
  logic [SLOTW-1:0] slot_q;
  logic [15:0]      row_cnt_q;
  logic [15:0]      rows_q;
  logic [CW-1:0]    credits_q;

  logic hs;
  logic take;
  logic start_acc;

  // A new line may only begin with a free credit; a started line always completes.
  always_comb begin
    bus.in_ready = (state_q == FILL) && ((col_q != '0) || (credits_q != '0));
    hs           = bus.in_valid && bus.in_ready;
    take         = hs && (col_q == '0);
    start_acc    = (state_q == IDLE) && start;
  end

  // Control FSM, address counters and registered write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      col_q     <= '0;
      bank_q    <= '0;
      slot_q    <= '0;
      row_cnt_q <= '0;
      rows_q    <= '0;
      bus.wen   <= 1'b0;
      bus.wdata <= '0;
      bus.wbank <= '0;
      bus.wrow  <= '0;
      bus.wcol  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      bus.wen <= 1'b0;
      done    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            col_q     <= '0;
            bank_q    <= '0;
            slot_q    <= '0;
            row_cnt_q <= '0;
            rows_q    <= num_rows;
            if (num_rows == '0) begin
              state_q <= DONE;
              done    <= 1'b1;
            end else begin
              state_q <= FILL;
              busy    <= 1'b1;
            end
          end
        end
        FILL: begin
          if (hs) begin
            bus.wen   <= 1'b1;
            bus.wdata <= bus.in_data[DW-1:0];
            bus.wbank <= 8'(bank_q);
            bus.wrow  <= 8'(slot_q);
            bus.wcol  <= 28'(col_q);
            if (col_q == COL_LAST) begin
              col_q     <= '0;
              row_cnt_q <= row_cnt_q + 16'd1;
              if (bank_q == BANK_LAST) begin
                bank_q <= '0;
                slot_q <= (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
              end else begin
                bank_q <= bank_q + 1'b1;
              end
              // done is raised together with the wen of the final word.
              if (row_cnt_q == rows_q - 16'd1) begin
                state_q <= DONE;
                done    <= 1'b1;
                busy    <= 1'b0;
              end
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Line credit pool; a release with the pool already full is dropped and flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits_q  <= CRED_FULL;
      credit_err <= 1'b0;
    end else begin
      if (start_acc) begin
        credit_err <= 1'b0;
      end
      if (line_rel && !take) begin
        if (credits_q == CRED_FULL) begin
          credit_err <= 1'b1;
        end else begin
          credits_q <= credits_q + 1'b1;
        end
      end else if (take && !line_rel) begin
        credits_q <= credits_q - 1'b1;
      end
    end
  end

`ifdef IBUF_SEQ_STATS_EN
  // Saturating count of FILL cycles where upstream offered data but was held off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (start_acc) begin
      stall_cnt <= '0;
    end else if ((state_q == FILL) && bus.in_valid && !bus.in_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ibuf_write_sequencer.sv
// Randomized self-checking bench for ibuf_write_sequencer. Expected writes are
// derived from the word index of the fill (row = k/BUFW, col = k%BUFW, ...),
// and line credits are tracked as a plain integer pool.
module tb_ibuf_write_sequencer;

  localparam int DW    = 32;
  localparam int POY   = 3;
  localparam int BUFW  = 32;
  localparam int BUFH  = 2;
  localparam int LINES = POY * BUFH;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] num_rows = '0;
  logic        line_rel = 1'b0;
  logic        busy, done, credit_err;
`ifdef IBUF_SEQ_STATS_EN
  logic [31:0] stall_cnt;
`endif

  ibuf_write_sequencer_if #(.DW(DW)) bus ();

  ibuf_write_sequencer #(
    .DW(DW), .POY(POY), .STRIDE(1), .BUFW(BUFW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .num_rows   (num_rows),
    .line_rel   (line_rel),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .credit_err (credit_err)
`ifdef IBUF_SEQ_STATS_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // reference model state
  int          m_k, m_total, m_cred;
  bit          m_fill, m_err;
  longint      m_stall;
  bit          e_wen, e_done;
  logic [31:0] e_data;
  int          e_bank, e_row, e_col;
  int          n_wen;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_k = 0; m_total = 0; m_cred = LINES; m_fill = 0; m_err = 0; m_stall = 0;
    e_wen = 0; e_done = 0; e_data = '0; e_bank = 0; e_row = 0; e_col = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_wen"},   bus.wen, 0);
    check_eq({tag, "_rdy"},   bus.in_ready, 0);
    check_eq({tag, "_busy"},  busy, 0);
    check_eq({tag, "_done"},  done, 0);
    check_eq({tag, "_cerr"},  credit_err, 0);
    check_eq({tag, "_wdata"}, bus.wdata, 0);
    check_eq({tag, "_wbank"}, bus.wbank, 0);
    check_eq({tag, "_wrow"},  bus.wrow, 0);
    check_eq({tag, "_wcol"},  bus.wcol, 0);
`ifdef IBUF_SEQ_STATS_EN
    check_eq({tag, "_stall"}, stall_cnt, 0);
`endif
  endtask

  // One clock: drive at negedge, check ready, advance model, check outputs after posedge.
  task automatic step(input bit v, input bit rel, input bit st);
    bit rdy, hs, take;
    logic [31:0] d;
    int y;
    @(negedge clk);
    d = $urandom;
    bus.in_valid = v;
    bus.in_data  = d;
    line_rel     = rel;
    start        = st;
    num_rows     = 16'd5;
    #1;
    rdy = m_fill && (((m_k % BUFW) != 0) || (m_cred > 0));
    check_eq("in_ready", bus.in_ready, rdy);
    hs   = v && rdy;
    take = hs && ((m_k % BUFW) == 0);
    if (rel && !take && m_cred == LINES) m_err = 1;
    else m_cred = m_cred + int'(rel) - int'(take);
    if (m_fill && v && !rdy && m_stall < 64'hffff_ffff) m_stall++;
    e_wen  = hs;
    e_done = 0;
    if (hs) begin
      y      = m_k / BUFW;
      e_col  = m_k % BUFW;
      e_bank = y % POY;
      e_row  = (y / POY) % BUFH;
      e_data = d;
      m_k++;
      if (m_k == m_total) begin
        m_fill = 0;
        e_done = 1;
      end
    end
    @(posedge clk);
    #1;
    if (bus.wen === 1'b1) n_wen++;
    check_eq("wen",        bus.wen, e_wen);
    check_eq("wdata",      bus.wdata, e_data);
    check_eq("wbank",      bus.wbank, e_bank);
    check_eq("wrow",       bus.wrow, e_row);
    check_eq("wcol",       bus.wcol, e_col);
    check_eq("done",       done, e_done);
    check_eq("busy",       busy, m_fill);
    check_eq("credit_err", credit_err, m_err);
`ifdef IBUF_SEQ_STATS_EN
    check_eq("stall_cnt",  stall_cnt, m_stall);
`endif
  endtask

  task automatic do_start(input int n);
    @(negedge clk);
    start = 1; num_rows = 16'(n); bus.in_valid = 0; line_rel = 0;
    @(posedge clk);
    #1;
    m_k = 0; m_total = n * BUFW; m_fill = (n != 0); m_err = 0; m_stall = 0;
    e_wen = 0; e_done = (n == 0);
    check_eq("start_busy", busy, m_fill);
    check_eq("start_done", done, e_done);
    check_eq("start_wen",  bus.wen, 0);
    check_eq("start_cerr", credit_err, 0);
    @(negedge clk);
    start = 0;
    e_done = 0;
  endtask

  task automatic restore_credits();
    for (int i = 0; i < 2 * LINES && m_cred < LINES; i++) step(0, 1, 0);
  endtask

  // Run the current fill to completion; rnd randomizes valid and releases.
  task automatic run_fill(input bit rnd, input int max_cyc);
    bit v, rel;
    for (int c = 0; c < max_cyc && m_fill; c++) begin
      if (rnd) begin
        v   = ($urandom_range(0, 3) != 0);
        rel = (m_cred < LINES) && ($urandom_range(0, 5) == 0);
      end else begin
        v   = 1;
        rel = (m_cred == 0) && ($urandom_range(0, 1) == 0);
      end
      step(v, rel, 0);
    end
    check_eq("fill_timeout", m_fill, 0);
    step(0, 0, 0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 0; start = 0; bus.in_valid = 0; line_rel = 0;
    #1;
    model_reset();
    check_all_zero("rst");
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 0;
    bus.in_data  = '0;
    model_reset();
    n_wen = 0;

    // reset state and quiet idle
    #2;
    check_all_zero("por");
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 10; i++) step(0, 0, 0);
    check_eq("idle_no_wen", n_wen, 0);

    // three rows, continuous valid: one line to each bank, slot 0
    do_start(3);
    n_wen = 0;
    run_fill(0, 200);
    check_eq("rows3_wen_count", n_wen, 96);

    // seven rows without releases: stalls after six lines, resumes on one release
    restore_credits();
    do_start(7);
    n_wen = 0;
    for (int i = 0; i < 200; i++) step(1, 0, 0);
    check_eq("stall_words", m_k, 192);
    check_eq("stall_wen_count", n_wen, 192);
    step(1, 1, 0);
    run_fill(0, 100);
    check_eq("rows7_wen_count", n_wen, 224);

    // release coinciding with the col-0 accept at one remaining credit
    restore_credits();
    do_start(8);
    for (int i = 0; i < 400 && !(m_cred == 1 && (m_k % BUFW) == 0); i++) step(1, 0, 0);
    check_eq("coinc_setup_cred", m_cred, 1);
    step(1, 1, 0);
    check_eq("coinc_cred_kept", m_cred, 1);
    run_fill(0, 400);

    // zero-row start, and start pulses ignored during a fill
    do_start(0);
    step(0, 0, 0);
    restore_credits();
    do_start(2);
    for (int i = 0; i < 4; i++) step(1, 0, 1);
    run_fill(1, 400);

    // release with a full pool is flagged and sticks until the next start
    restore_credits();
    step(0, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0);
    do_start(4);
    run_fill(1, 800);

    // reset in the middle of a line, then a clean fill from the origin
    restore_credits();
    do_start(3);
    for (int i = 0; i < 10; i++) step(1, 0, 0);
    apply_reset();
    do_start(2);
    run_fill(1, 400);

    // random fills
    for (int t = 0; t < 6; t++) begin
      do_start($urandom_range(1, 9));
      run_fill(1, 2000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
